// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage.
// Contents: instruction opcode constants, the $rstatus exception instruction,
// status codes written to $rstatus, and the request FSM state encoding.
package memory_stage_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  // addi $r30 -- writes a status code into $rstatus
  localparam logic [31:0] RSTATUS_INSN = 32'h2F80_0000;

  // Status codes 1-5 come from the ALU; 6 is raised here
  localparam logic [31:0] STATUS_ADD_OVF    = 32'd1;
  localparam logic [31:0] STATUS_SUB_OVF    = 32'd2;
  localparam logic [31:0] STATUS_MUL_OVF    = 32'd3;
  localparam logic [31:0] STATUS_DIV_ZERO   = 32'd4;
  localparam logic [31:0] STATUS_BAD_INSN   = 32'd5;
  localparam logic [31:0] STATUS_MEMTIMEOUT = 32'd6;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] insn);
    return insn[31:27];
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus.
// master (memory stage): req, we, addr, wdata out; ack, rdata in.
// slave  (memory):       the reverse.
// ack completes the request in the same cycle and rdata is valid with it.
interface memory_stage_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/memory_stage_mem_req_fsm.sv
// Memory request sequencer with watchdog.
// Ports: clock, reset (async, active-low), is_mem (stage holds lw/sw),
// ack (memory done), stall (hold upstream), req (memory request),
// timeout (watchdog expired in WAIT this cycle).
module mem_req_fsm
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic is_mem,
  input  logic ack,
  output logic stall,
  output logic req,
  output logic timeout
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    req     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        // ack is deliberately not looked at here: the request only
        // becomes visible to memory this cycle.
        cnt_d = '0;
        if (is_mem) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        timeout = (cnt_q == CNT_W'(TIMEOUT));
        // A coincident ack still completes the access normally.
        req     = ack | ~timeout;
        stall   = ~ack & ~timeout;
        if (ack || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/singleRegister.sv
// Generic enabled register with asynchronous active-high clear.
// Ports: clock, clear (async, high), enable (load when 1), d in, q out.
module singleRegister #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: lw/sw through a req/ack data-memory bus.
// Ports: clock, reset (async, active-low); insnIn/aluIn/storeIn from execute;
// stall to upstream; dmem (master side of the memory bus);
// insnOut/dataOut registered toward writeback (dataOut is also forwarded).
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          insnIn,
  input  logic [31:0]          aluIn,
  input  logic [31:0]          storeIn,
  output logic                 stall,
  memory_stage_if.master       dmem,
  output logic [31:0]          insnOut,
  output logic [31:0]          dataOut
);

  logic        clear;
  logic [31:0] insn_q, alu_q, st_q;
  logic [31:0] insn_out_d, data_out_d;
  logic        is_lw, is_sw, is_mem;
  logic        req, timeout, abort;

  assign clear = ~reset;

  singleRegister #(.WIDTH(96)) u_stage_reg (
    .clock  (clock),
    .clear  (clear),
    .enable (~stall),
    .d      ({insnIn, aluIn, storeIn}),
    .q      ({insn_q, alu_q, st_q})
  );

  always_comb begin
    is_lw  = (opcode_of(insn_q) == OP_LW);
    is_sw  = (opcode_of(insn_q) == OP_SW);
    is_mem = (is_lw | is_sw) & (insn_q != 32'd0);
  end

  mem_req_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_fsm (
    .clock   (clock),
    .reset   (reset),
    .is_mem  (is_mem),
    .ack     (dmem.ack),
    .stall   (stall),
    .req     (req),
    .timeout (timeout)
  );

  assign dmem.req   = req;
  assign dmem.we    = is_sw & req;
  assign dmem.addr  = alu_q[ADDR_W-1:0];
  assign dmem.wdata = st_q;

  assign abort = timeout & ~dmem.ack;

  always_comb begin
    insn_out_d = 32'd0;
    data_out_d = 32'd0;
    if (abort) begin
      // Abandoned access is replaced by the $rstatus exception write.
      insn_out_d = RSTATUS_INSN;
      data_out_d = STATUS_MEMTIMEOUT;
    end else if (!stall) begin
      insn_out_d = insn_q;
      // Writes to $r0 carry no data; sw has no writeback value.
      if (insn_q[26:22] != 5'd0) begin
        if (is_lw) begin
          data_out_d = dmem.rdata;
        end else if (!is_sw) begin
          data_out_d = alu_q;
        end
      end
    end
  end

  singleRegister #(.WIDTH(64)) u_out_reg (
    .clock  (clock),
    .clear  (clear),
    .enable (1'b1),
    .d      ({insn_out_d, data_out_d}),
    .q      ({insnOut, dataOut})
  );

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with an output scoreboard and a small
// latency-programmable memory responder.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] insnIn = 32'd0, aluIn = 32'd0, storeIn = 32'd0;
  logic        stall;
  logic [31:0] insnOut, dataOut;

  memory_stage_if #(.ADDR_W(ADDR_W)) dmem_bus ();

  memory_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .insnIn  (insnIn),
    .aluIn   (aluIn),
    .storeIn (storeIn),
    .stall   (stall),
    .dmem    (dmem_bus),
    .insnOut (insnOut),
    .dataOut (dataOut)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          ack_lat = -1;
  int          req_cnt = 0;
  bit          force_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  int          stall_cycles, req_cycles;
  bit          we_seen, accepted, ack_prev, b2b_chk;
  logic [31:0] last_addr, last_wdata;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    stall_cycles = 0;
    req_cycles   = 0;
    we_seen      = 1'b0;
    last_addr    = 32'hFFFF_FFFF;
    last_wdata   = 32'd0;
  endtask

  // One clock: memory responds at the negedge, stage state is sampled just
  // after it, and the output register is checked just after the posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    if (dmem_bus.req) begin
      if (ack_lat >= 0 && req_cnt == ack_lat) begin
        dmem_bus.ack = 1'b1;
        req_cnt = 0;
      end else begin
        dmem_bus.ack = 1'b0;
        req_cnt++;
      end
    end else begin
      dmem_bus.ack = force_ack;
      req_cnt = 0;
    end
    dmem_bus.rdata = mem_rdata;
    #1;
    if (b2b_chk && ack_prev) begin
      chk("b2b_req", 32'(dmem_bus.req), 32'd1);
      b2b_chk = 1'b0;
    end
    ack_prev = dmem_bus.ack;
    if (stall) stall_cycles++;
    if (dmem_bus.req) begin
      req_cycles++;
      last_addr = 32'(dmem_bus.addr);
      if (dmem_bus.we) begin
        we_seen    = 1'b1;
        last_wdata = dmem_bus.wdata;
      end
    end
    accepted = !stall;
    @(posedge clock);
    #1;
    if (insnOut !== 32'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", insnOut, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("out insn=0x%08h data=0x%08h", insnOut, dataOut);
        chk("insnOut", insnOut, e.insn);
        chk("dataOut", dataOut, e.data);
      end
    end else begin
      chk("bubble_data", dataOut, 32'd0);
    end
  endtask

  task automatic present(input logic [31:0] insn, input logic [31:0] alu,
                         input logic [31:0] st, input logic [31:0] exp_insn,
                         input logic [31:0] exp_data);
    insnIn  = insn;
    aluIn   = alu;
    storeIn = st;
    sb.push_back(exp_t'({exp_insn, exp_data}));
    accepted = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    insnIn  = 32'd0;
    aluIn   = 32'd0;
    storeIn = 32'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] add3, lw4, sw5, lw6, lw7, add8, lw9, add10, add0;

  initial begin
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'd0;
    add3  = mk(OP_RTYPE, 5'd3, 5'd1, 5'd2);
    lw4   = mk(OP_LW,    5'd4, 5'd1, 5'd0);
    sw5   = mk(OP_SW,    5'd5, 5'd1, 5'd0);
    lw6   = mk(OP_LW,    5'd6, 5'd1, 5'd0);
    lw7   = mk(OP_LW,    5'd7, 5'd2, 5'd0);
    add8  = mk(OP_RTYPE, 5'd8, 5'd3, 5'd4);
    lw9   = mk(OP_LW,    5'd9, 5'd1, 5'd0);
    add10 = mk(OP_RTYPE, 5'd10, 5'd1, 5'd2);
    add0  = mk(OP_RTYPE, 5'd0, 5'd1, 5'd2);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_we", 32'(dmem_bus.we), 32'd0);
    chk("rst_insnOut", insnOut, 32'd0);
    chk("rst_dataOut", dataOut, 32'd0);
    reset = 1'b1;

    // Non-mem op passes through without stalling
    clear_stats();
    present(add3, 32'd7, 32'd0, add3, 32'd7);
    drain();
    chk("add_stalls", 32'(stall_cycles), 32'd0);

    // lw acked 3 cycles after the first request
    ack_lat = 3;
    mem_rdata = 32'hDEAD_BEEF;
    clear_stats();
    present(lw4, 32'h010, 32'd0, lw4, 32'hDEAD_BEEF);
    drain();
    chk("lw_stalls", 32'(stall_cycles), 32'd3);
    chk("lw_req_cycles", 32'(req_cycles), 32'd4);
    chk("lw_addr", last_addr, 32'h010);
    chk("lw_we", 32'(we_seen), 32'd0);

    // sw acked on the first WAIT cycle, then a back-to-back lw
    ack_lat = 1;
    mem_rdata = 32'hCAFE_0001;
    clear_stats();
    b2b_chk  = 1'b1;
    ack_prev = 1'b0;
    present(sw5, 32'h014, 32'h1234_5678, sw5, 32'd0);
    present(lw6, 32'h018, 32'd0, lw6, 32'hCAFE_0001);
    drain();
    chk("sw_we", 32'(we_seen), 32'd1);
    chk("sw_wdata", last_wdata, 32'h1234_5678);
    chk("swlw_stalls", 32'(stall_cycles), 32'd2);
    chk("swlw_req_cycles", 32'(req_cycles), 32'd4);
    chk("lw6_addr", last_addr, 32'h018);
    chk("b2b_seen", 32'(b2b_chk), 32'd0);

    // lw never acked: watchdog aborts into the $rstatus write
    ack_lat = -1;
    mem_rdata = 32'h55AA_55AA;
    clear_stats();
    present(lw7, 32'h020, 32'd0, RSTATUS_INSN, STATUS_MEMTIMEOUT);
    drain();
    chk("to_stalls", 32'(stall_cycles), 32'(TIMEOUT + 1));
    chk("to_req_cycles", 32'(req_cycles), 32'(TIMEOUT + 1));
    clear_stats();
    present(add8, 32'h11, 32'd0, add8, 32'h11);
    drain();
    chk("post_to_stalls", 32'(stall_cycles), 32'd0);

    // Reset asserted mid-WAIT
    present(lw9, 32'h030, 32'd0, lw9, 32'd0);
    cycle();
    cycle();
    @(negedge clock);
    #1;
    chk("pre_rst_req", 32'(dmem_bus.req), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(dmem_bus.req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_we", 32'(dmem_bus.we), 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_insnOut", insnOut, 32'd0);
    chk("post_rst_dataOut", dataOut, 32'd0);
    clear_stats();
    present(add10, 32'h21, 32'd0, add10, 32'h21);
    drain();
    chk("post_rst_stalls", 32'(stall_cycles), 32'd0);
    chk("post_rst_req", 32'(req_cycles), 32'd0);

    // rd=0 forces zero data; ack while IDLE with a non-mem op is ignored
    clear_stats();
    force_ack = 1'b1;
    present(add0, 32'd9, 32'd0, add0, 32'd0);
    drain();
    force_ack = 1'b0;
    chk("rd0_stalls", 32'(stall_cycles), 32'd0);
    chk("rd0_req", 32'(req_cycles), 32'd0);

    // Upstream exception instruction passes unchanged
    clear_stats();
    present(RSTATUS_INSN, 32'd3, 32'd0, RSTATUS_INSN, 32'd3);
    drain();
    chk("exc_stalls", 32'(stall_cycles), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the executed instruction, the ALU result and the store operand.
- Performs lw/sw accesses to data memory through a req/ack handshake with variable latency.
- Stalls upstream while an access is outstanding, then hands instruction and result to writeback.
- A watchdog turns a memory access that never completes into a $rstatus exception write.

Parameters:
- ADDR_W, 12, width of data-memory word address driven from ALU result bits [ADDR_W-1:0]
- TIMEOUT, 15, maximum cycles in WAIT before abort; must be < 2^CNT_W
- CNT_W, 4, width of watchdog counter

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state when 0
- insnIn  in  32  instruction from execute stage
- aluIn  in  32  execute result (effective address for lw/sw, result otherwise)
- storeIn  in  32  register value to store for sw
- stall  out  1  upstream must hold its pipeline registers while 1
- dmem_req  out  1  memory request, held high until acknowledged
- dmem_we  out  1  1 = write (sw), 0 = read (lw); valid while dmem_req
- dmem_addr  out  ADDR_W  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completes request this cycle; rdata valid same cycle
- dmem_rdata  in  32  load data
- insnOut  out  32  registered instruction to writeback
- dataOut  out  32  registered writeback data (also the forwarding source)

Behaviour:
- Stage register holds insn_q, alu_q and st_q. It loads insnIn, aluIn and storeIn on every edge where stall=0 and holds otherwise.
- opcode_q = insn_q[31:27]. is_lw = (opcode_q==01000). is_sw = (opcode_q==00111). is_mem = is_lw|is_sw, forced 0 when insn_q==0.
- dmem_addr = alu_q[ADDR_W-1:0]. dmem_wdata = st_q. dmem_we = is_sw & dmem_req.
- FSM states: IDLE and WAIT.
  - IDLE, is_mem=0: stall=0, dmem_req=0. The instruction passes through with zero added latency.
  - IDLE, is_mem=1: dmem_req=1, stall=1, counter cleared, next state WAIT. dmem_ack is ignored in IDLE.
  - WAIT: dmem_req=1, counter increments. stall = ~dmem_ack & ~timeout, where timeout = (counter==TIMEOUT).
  - WAIT with dmem_ack: next state IDLE. The stage advances on that edge. If ack and timeout occur in the same cycle, ack wins.
  - WAIT with timeout and no ack: dmem_req drops, next state IDLE, and the stage advances. The output register receives insn 32'h2F800000 (addi $r30) and data 32'd6.
- Minimum occupancy: a mem op takes 2 cycles in the stage (1 stall cycle plus the ack cycle). Non-mem ops take 1 cycle.
- Output register (insnOut, dataOut) loads every edge:
  - Stage advancing normally: insnOut = insn_q. dataOut = dmem_rdata for lw, alu_q otherwise (sw data is don't-care; 0 is required).
  - Stall cycle: insnOut = 0 and dataOut = 0, a bubble. Writeback never sees a duplicate.
  - Rd-field rule: insn_q[26:22]==0 forces dataOut=0, except for the timeout exception.
- The execute-stage exception insn (addi $r30) is not a mem op and passes through unchanged.
- Reset (reset=0, any cycle including mid-WAIT):
  - state=IDLE; counter, stage register and output register all 0.
  - stall, dmem_req and dmem_we drop to 0 immediately.
  - An abandoned memory transaction is not retried.
- No combinational path from dmem_rdata to outputs other than into dataOut flops. dmem_ack → stall is combinational by design.

Decomposition:
- Shared package/include holds:
  - opcode constants OP_RTYPE=00000, OP_ADDI=00101, OP_SW=00111, OP_LW=01000.
  - RSTATUS_INSN=32'h2F800000.
  - status codes 1–5 (ALU) and STATUS_MEMTIMEOUT=6.
  - FSM state encoding IDLE=0, WAIT=1.
- Stage and output registers reuse the existing singleRegister, with enable=~stall for the stage register and clear driven from inverted reset.
- One new sub-module, mem_req_fsm, owns the state, watchdog counter, stall, dmem_req and the timeout flag.

Test Plan:
1. add $3,$1,$2 with aluIn=7 → stall never 1; next cycle insnOut=insn, dataOut=7.
2. lw $4,0($1) with aluIn=0x010, ack 3 cycles after first req, rdata=0xDEADBEEF:
   - stall=1 for 3 cycles, dmem_req high through the ack cycle, dmem_addr=0x010, dmem_we=0.
   - Bubbles go out during stall; then insnOut=lw, dataOut=0xDEADBEEF.
3. sw $5,4($1) with storeIn=0x12345678 and ack on the first WAIT cycle → dmem_we=1, dmem_wdata=0x12345678; stage occupied 2 cycles; back-to-back lw then issues a req on the next cycle.
4. lw with no ack → after TIMEOUT=15 WAIT cycles, req drops, insnOut=0x2F800000, dataOut=6, state IDLE.
5. reset pulled low during WAIT → dmem_req and stall fall without waiting for a clock edge; after release, insnOut=0 and a new add passes normally.
6. Insn with rd=0 (add $0,$1,$2, aluIn=9) → dataOut=0; ack asserted while IDLE with a non-mem op → ignored, no stall.
